// File: rtl/bidir_pad_sched.sv
// bidir_pad_sched: round-robin scheduler sharing one bidirectional tristate pad
// between requesters A and B. Transactions are WIDTH bits, bit-serial, MSB first.
// Writes drive the pad and are followed by TURN_CYC released cycles. Reads
// release the pad and shift the sampled level into the LSB of the shift register.
// Optional macro BIDIR_PAD_SYNC_EN: adds a 2-flop synchronizer on pad_o and
// extends SAMPLE by 2 cycles, so the captured bits still line up with SAMPLE
// cycles 1..WIDTH.
module bidir_pad_sched #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             req_a,
    input  logic             wr_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic             wr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             ack_b,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             pad_t,
    output logic             pad_i,
    input  logic             pad_o
);

`ifdef BIDIR_PAD_SYNC_EN
    localparam int SAMPLE_CYC = WIDTH + 2;
`else
    localparam int SAMPLE_CYC = WIDTH;
`endif
    // Wide enough for WIDTH+2 sample cycles (max 34) and TURN_CYC (max 15).
    localparam int CW = 6;

    typedef enum logic [2:0] {IDLE, DRIVE, TURN, SAMPLE, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             last_b, last_b_next;
    logic             sel_b, sel_b_next;
    logic             grant_b;
    logic [WIDTH-1:0] rdata_next;
    logic             ack_a_next, ack_b_next;
    logic             pad_t_next, pad_i_next, busy_next;
    logic             pad_bit;

`ifdef BIDIR_PAD_SYNC_EN
    logic sync1, sync2;

    // Two-flop synchronizer bringing the pad level into the clock domain.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pad_o;
            sync2 <= sync1;
        end
    end

    assign pad_bit = sync2;
`else
    assign pad_bit = pad_o;
`endif

    // Next-state logic; outputs are computed from the next state so they register cleanly.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        last_b_next = last_b;
        sel_b_next  = sel_b;
        rdata_next  = rdata;
        grant_b     = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    grant_b     = req_b && (!req_a || !last_b);
                    sel_b_next  = grant_b;
                    last_b_next = grant_b;
                    shreg_next  = grant_b ? wdata_b : wdata_a;
                    if (grant_b ? wr_b : wr_a) begin
                        state_next = DRIVE;
                        cnt_next   = CW'(WIDTH - 1);
                    end else begin
                        state_next = SAMPLE;
                        cnt_next   = CW'(SAMPLE_CYC - 1);
                    end
                end
            end
            DRIVE: begin
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
                if (cnt == '0) begin
                    if (TURN_CYC == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = TURN;
                        cnt_next   = CW'(TURN_CYC - 1);
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            SAMPLE: begin
                shreg_next = {shreg[WIDTH-2:0], pad_bit};
                if (cnt == '0) begin
                    state_next = DONE;
                    rdata_next = shreg_next;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        ack_a_next = (state_next == DONE) && !sel_b_next;
        ack_b_next = (state_next == DONE) && sel_b_next;
        pad_t_next = (state_next != DRIVE);
        pad_i_next = (state_next == DRIVE) ? shreg_next[WIDTH-1] : 1'b0;
        busy_next  = (state_next != IDLE);
    end

    // State and registered outputs; reset aborts any transaction and releases the pad.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            last_b <= 1'b1;
            sel_b  <= 1'b0;
            rdata  <= '0;
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            pad_t  <= 1'b1;
            pad_i  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            shreg  <= shreg_next;
            cnt    <= cnt_next;
            last_b <= last_b_next;
            sel_b  <= sel_b_next;
            rdata  <= rdata_next;
            ack_a  <= ack_a_next;
            ack_b  <= ack_b_next;
            pad_t  <= pad_t_next;
            pad_i  <= pad_i_next;
            busy   <= busy_next;
        end
    end

endmodule
